mvm_sched: RTL
==============

MVM_SCHED -- requirements
Module: mvm_sched

Interface
REQ-001 Parameter MAT_SCALE, default 4: matrix dimension N; must be a power of 2, at least 2.
REQ-002 Parameter INPUT_WIDTH, default 8: width of A and x elements, signed.
REQ-003 Parameter OUTPUT_WIDTH, default 16: width of y elements, signed.
REQ-004 Parameter TIMEOUT, default 64: maximum number of cycles spent in WAIT before abort.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req  in  2  per-requester job request, level-sensitive; bit i belongs to requester i.
REQ-008 req_data0, req_data1  in  INPUT_WIDTH each  operand stream from requester 0 and requester 1.
REQ-009 gnt  out  2  one-hot grant; high on every cycle the owning requester must drive an operand word.
REQ-010 rsp_valid  out  2  one-hot; high while rsp_data carries a y element for that requester.
REQ-011 rsp_data  out  OUTPUT_WIDTH  y element being returned.
REQ-012 err  out  2  one-cycle pulse to requester i when its job is aborted by timeout.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 eng_start  out  1  one-cycle start pulse to the shared MVM engine.
REQ-015 eng_data_in  out  INPUT_WIDTH  operand word to the engine.
REQ-016 eng_done  in  1  engine pulse; y[0] is on eng_data_out the cycle after it.
REQ-017 eng_data_out  in  OUTPUT_WIDTH  engine result stream.

Function
REQ-018 States are IDLE, START, LOAD, WAIT, DRAIN and ABORT; the state encoding is free.
REQ-019 Arbitration is round-robin, evaluated only in IDLE, via a pointer last.
REQ-020 If only req[i] is high, requester i wins.
REQ-021 If both req bits are high, the requester that is not last wins.
REQ-022 The winner is registered as owner and last is updated to owner.
REQ-023 IDLE -> START when any req bit is high; eng_start is high for exactly the one START cycle.
REQ-024 START -> LOAD unconditionally.
REQ-025 LOAD lasts exactly N*N+N cycles; gnt[owner] is high on every LOAD cycle and on no other cycle.
REQ-026 In LOAD, eng_data_in equals req_data<owner> combinationally on the same cycle; words 0..N*N-1 are A in row-major order and the last N words are x.
REQ-027 In all states other than LOAD, eng_data_in is 0.
REQ-028 The load counter is $clog2(N*N+N)+1 bits wide, clears on entry to LOAD, and moves to WAIT on the cycle it reaches N*N+N-1.
REQ-029 WAIT -> DRAIN on eng_done; the wait counter clears on entry to WAIT.
REQ-030 If eng_done has not arrived after TIMEOUT cycles in WAIT, move WAIT -> ABORT.
REQ-031 ABORT lasts 1 cycle with err[owner]=1, then moves to IDLE.
REQ-032 An eng_done outside WAIT is ignored.
REQ-033 DRAIN lasts exactly N cycles; rsp_valid[owner]=1 and rsp_data=eng_data_out, passed through unregistered and unmodified.
REQ-034 After the last DRAIN cycle, move to IDLE; a new job cannot start before the following cycle, so there is one idle cycle between jobs.
REQ-035 Outside DRAIN, rsp_valid=0 and rsp_data=0.
REQ-036 A req bit dropping after the grant does not cancel the job; the job always runs to DRAIN or ABORT.
REQ-037 Requests are never lost: a requester still holding req is served within one job of the other requester.
REQ-038 gnt, rsp_valid and err are each one-hot or zero, and at most one of the three is non-zero on any cycle.

Reset
REQ-039 While reset=0, the block is in IDLE with owner=0, last=1, and all counters 0.
REQ-040 While reset=0, all outputs (gnt, rsp_valid, rsp_data, err, busy, eng_start, eng_data_in) are 0.
REQ-041 Reset asserted mid-job abandons the job immediately with no err pulse.
REQ-042 After reset is released, the first arbitration favours requester 0.

Verification
REQ-043 Single job, N=4: req=01 with a ramp 1..20 on req_data0 -> eng_start one cycle, gnt=01 for 20 cycles, eng_data_in ramps 1..20; eng_done then y=5,6,7,8 -> rsp_valid=01 for 4 cycles with rsp_data 5,6,7,8.
REQ-044 Contention: req=11 held after reset -> jobs granted to 0, 1, 0, 1 in turn, each separated by one IDLE cycle.
REQ-045 Timeout, TIMEOUT=64: no eng_done after LOAD -> exactly 64 WAIT cycles, err=01 for 1 cycle, busy falls, the next request is accepted.
REQ-046 Reset driven low on LOAD cycle 10 -> all outputs 0 immediately; after release, req=10 -> gnt=10 follows the START cycle.
REQ-047 Spurious eng_done during LOAD -> ignored, with LOAD length still 20.
REQ-048 req dropped during LOAD -> job completes with 4 rsp_valid cycles.
REQ-049 Throughout every scenario, assertions check the one-hot rules of REQ-038 and that busy equals "state is not IDLE".

Source files
------------

// File: rtl/mvm_sched.sv
// Round-robin scheduler sharing one matrix-vector engine between two requesters.
// Streams A and x from the owner into the engine, then returns y to that owner.
module mvm_sched #(
    parameter int MAT_SCALE    = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req,
    input  logic [INPUT_WIDTH-1:0]  req_data0,
    input  logic [INPUT_WIDTH-1:0]  req_data1,
    output logic [1:0]              gnt,
    output logic [1:0]              rsp_valid,
    output logic [OUTPUT_WIDTH-1:0] rsp_data,
    output logic [1:0]              err,
    output logic                    busy,
    output logic                    eng_start,
    output logic [INPUT_WIDTH-1:0]  eng_data_in,
    input  logic                    eng_done,
    input  logic [OUTPUT_WIDTH-1:0] eng_data_out
);

    localparam int LOAD_LEN = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int LCW = $clog2(LOAD_LEN) + 1;
    localparam int WCW = $clog2(TIMEOUT) + 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_LEN - 1);
    localparam logic [LCW-1:0] DRAIN_LAST = LCW'(MAT_SCALE - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_WAIT, S_DRAIN, S_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [LCW-1:0]   lcnt_q, lcnt_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       err_q, err_d;
    logic             busy_q, busy_d;
    logic             eng_start_q, eng_start_d;
    logic             win;
    logic [1:0]       sel;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        lcnt_d  = lcnt_q;
        wcnt_d  = wcnt_q;
        win     = req[1] & ~(req[0] & last_q);
        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = win;
                    last_d  = win;
                    state_d = S_START;
                end
            end
            S_START: begin
                lcnt_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (lcnt_q == LOAD_LAST) begin
                    lcnt_d  = '0;
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    lcnt_d  = '0;
                    state_d = S_DRAIN;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (lcnt_q == DRAIN_LAST) begin
                    lcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they are glitch-free.
        sel         = owner_d ? 2'b10 : 2'b01;
        gnt_d       = (state_d == S_LOAD) ? sel : 2'b00;
        rsp_valid_d = (state_d == S_DRAIN) ? sel : 2'b00;
        err_d       = (state_d == S_ABORT) ? sel : 2'b00;
        busy_d      = (state_d != S_IDLE);
        eng_start_d = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lcnt_q      <= '0;
            wcnt_q      <= '0;
            gnt_q       <= 2'b00;
            rsp_valid_q <= 2'b00;
            err_q       <= 2'b00;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lcnt_q      <= lcnt_d;
            wcnt_q      <= wcnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;

    assign eng_data_in = gnt_q[1] ? req_data1 :
                         gnt_q[0] ? req_data0 : '0;
    assign rsp_data    = (rsp_valid_q != 2'b00) ? eng_data_out : '0;

endmodule
